// File: rtl/apple2_bus_master.sv
// apple2_bus_master
// Emulates the 6502/motherboard side of one Apple II peripheral slot.
// A 7-state counter driven by C7M produces PHI1/PHI0; one bus cycle spans
// S7..S6 (7 C7M periods). Host requests are accepted on the edge ending S6
// and become the next bus cycle, with slot-decoded selects in S3..S6.
//
// Ports:
//   C7M        master clock (all logic on posedge)
//   nRES       asynchronous active-low reset
//   req_valid  host request pending
//   req_ready  high during S6; request taken on that edge if req_valid
//   req_addr   6502 address, req_write 1=write, req_wdata write data
//   rsp_valid  one-cycle completion pulse (in the S7 after the cycle)
//   rsp_rdata  read data of last response (8'h00 after a write)
//   PHI1/PHI0  bus phases
//   A, nWE     address bus and R/W (high = read)
//   D          data bus, driven only in S4..S6 of a write cycle
//   nDEVSEL, nIOSEL, nIOSTRB  active-low slot selects
module apple2_bus_master #(
  parameter int SLOT = 4
) (
  input  logic        C7M,
  input  logic        nRES,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic        req_write,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        PHI1,
  output logic        PHI0,
  output logic [15:0] A,
  output logic        nWE,
  inout  wire  [7:0]  D,
  output logic        nDEVSEL,
  output logic        nIOSEL,
  output logic        nIOSTRB
);

  typedef enum logic [2:0] {
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6,
    S7 = 3'd7
  } state_t;

  // Address page (A[15:4]) of this slot's DEVSEL window and A[15:8] of its IOSEL page.
  localparam logic [11:0] DEVSEL_PAGE = 12'hC08 + 12'(SLOT);
  localparam logic [7:0]  IOSEL_PAGE  = 8'hC0 + 8'(SLOT);

  state_t      state_r;
  state_t      next_state_s;
  logic        phi1_next_s;
  logic        phi0_next_s;
  logic        cur_active_r;
  logic        cur_write_r;
  logic [7:0]  wdata_r;
  logic        drive_r;

  // Active-high select decode {devsel, iosel, iostrb}; ranges are disjoint.
  function automatic logic [2:0] decode_sel(input logic [11:0] page);
    logic [2:0] sel;
    sel[2] = (page == DEVSEL_PAGE);
    sel[1] = (page[11:4] == IOSEL_PAGE);
    sel[0] = (page[11:7] == 5'b11001);
    return sel;
  endfunction

  // Master drives D only while its write-data window is open.
  assign D = drive_r ? wdata_r : 8'hzz;

  // Next-state sequencing and phase levels for the state being entered.
  always_comb begin
    next_state_s = S1;
    phi1_next_s  = 1'b1;
    phi0_next_s  = 1'b0;
    case (state_r)
      S1:      next_state_s = S2;
      S2:      next_state_s = S3;
      S3:      next_state_s = S4;
      S4:      next_state_s = S5;
      S5:      next_state_s = S6;
      S6:      next_state_s = S7;
      S7:      next_state_s = S1;
      default: next_state_s = S1;
    endcase
    if ((next_state_s == S3) || (next_state_s == S4) ||
        (next_state_s == S5) || (next_state_s == S6)) begin
      phi1_next_s = 1'b0;
      phi0_next_s = 1'b1;
    end else begin
      phi1_next_s = 1'b1;
      phi0_next_s = 1'b0;
    end
  end

  // Bus-cycle sequencer with registered phases, selects, data drive and response.
  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      state_r      <= S7;
      PHI1         <= 1'b1;
      PHI0         <= 1'b0;
      req_ready    <= 1'b0;
      A            <= 16'h0000;
      nWE          <= 1'b1;
      nDEVSEL      <= 1'b1;
      nIOSEL       <= 1'b1;
      nIOSTRB      <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 8'h00;
      cur_active_r <= 1'b0;
      cur_write_r  <= 1'b0;
      wdata_r      <= 8'h00;
      drive_r      <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      PHI1      <= phi1_next_s;
      PHI0      <= phi0_next_s;
      req_ready <= (next_state_s == S6);
      rsp_valid <= 1'b0;
      case (state_r)
        S2: begin
          // Entering S3: A has been stable since S7, so selects may assert.
          if (cur_active_r) begin
            {nDEVSEL, nIOSEL, nIOSTRB} <= ~decode_sel(A[15:4]);
          end else begin
            {nDEVSEL, nIOSEL, nIOSTRB} <= 3'b111;
          end
        end
        S3: begin
          drive_r <= cur_active_r && cur_write_r;
        end
        S6: begin
          // PHI0 falling: close the current cycle and open the next one.
          {nDEVSEL, nIOSEL, nIOSTRB} <= 3'b111;
          drive_r   <= 1'b0;
          rsp_valid <= cur_active_r;
          if (cur_active_r) begin
            rsp_rdata <= cur_write_r ? 8'h00 : D;
          end
          if (req_valid) begin
            cur_active_r <= 1'b1;
            A            <= req_addr;
            nWE          <= ~req_write;
            cur_write_r  <= req_write;
            wdata_r      <= req_wdata;
          end else begin
            // Idle cycle: A keeps its previous value.
            cur_active_r <= 1'b0;
            nWE          <= 1'b1;
            cur_write_r  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apple2_bus_master.sv
// Testbench for apple2_bus_master: transaction-level reference model checked
// on every falling C7M edge, table-driven single transactions, hand-written
// back-to-back / withdraw / mid-cycle reset sequences, then random traffic.
module tb_apple2_bus_master;
  localparam int SLOT = 4;
  localparam int DEV_LO = 32'hC080 + 16 * SLOT;
  localparam int IO_LO  = 32'hC000 + 256 * SLOT;
  localparam logic [31:0] RESET_VEC = 32'h80001E00;

  logic        C7M;
  logic        nRES;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_write;
  logic [7:0]  req_wdata;
  wire         req_ready;
  wire         rsp_valid;
  wire  [7:0]  rsp_rdata;
  wire         PHI1;
  wire         PHI0;
  wire  [15:0] A;
  wire         nWE;
  wire  [7:0]  d_bus;
  wire         nDEVSEL;
  wire         nIOSEL;
  wire         nIOSTRB;

  logic        tb_drive;
  logic [7:0]  tb_data;
  assign d_bus = tb_drive ? tb_data : 8'hzz;

  apple2_bus_master #(.SLOT(SLOT)) dut (
    .C7M(C7M), .nRES(nRES),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .PHI1(PHI1), .PHI0(PHI0), .A(A), .nWE(nWE), .D(d_bus),
    .nDEVSEL(nDEVSEL), .nIOSEL(nIOSEL), .nIOSTRB(nIOSTRB)
  );

  initial C7M = 1'b0;
  always #5 C7M = ~C7M;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_dev, n_io, n_strb, n_rsp;
  int rsp_q[$];
  logic [7:0] next_rdata;

  // Reference model: position in the 7-state bus cycle and the request it carries.
  int          m_s;
  logic        m_cur_valid;
  logic [15:0] m_cur_addr;
  logic        m_cur_write;
  logic [7:0]  m_cur_wdata;
  logic [7:0]  m_cur_rdata;
  logic [15:0] m_A;
  logic        m_rsp;
  logic [7:0]  m_rdata;

  always @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      m_s <= 7; m_cur_valid <= 1'b0; m_cur_addr <= 16'h0000; m_cur_write <= 1'b0;
      m_cur_wdata <= 8'h00; m_cur_rdata <= 8'h00; m_A <= 16'h0000;
      m_rsp <= 1'b0; m_rdata <= 8'h00;
    end else begin
      m_s   <= (m_s == 7) ? 1 : m_s + 1;
      m_rsp <= (m_s == 6) && m_cur_valid;
      if (m_s == 6) begin
        if (m_cur_valid) m_rdata <= m_cur_write ? 8'h00 : m_cur_rdata;
        m_cur_valid <= req_valid;
        if (req_valid) begin
          m_cur_addr  <= req_addr;
          m_A         <= req_addr;
          m_cur_write <= req_write;
          m_cur_wdata <= req_wdata;
          m_cur_rdata <= next_rdata;
        end
      end
    end
  end

  function automatic logic [2:0] exp_sel(input logic [15:0] a);
    int v;
    logic [2:0] s;
    v = int'(a);
    s[2] = (v >= DEV_LO) && (v < DEV_LO + 16);
    s[1] = (v >= IO_LO) && (v < IO_LO + 256);
    s[0] = (v >= 32'hC800) && (v <= 32'hCFFF);
    return s;
  endfunction

  function automatic logic [31:0] bus_vec();
    return {PHI1, PHI0, req_ready, A, nWE, nDEVSEL, nIOSEL, nIOSTRB, rsp_valid, rsp_rdata};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and compare every output to the model.
  task automatic tick();
    logic [2:0] sel;
    logic e_phi1, e_phi0, e_rdy, e_nwe;
    @(negedge C7M);
    cyc++;
    sel = (m_cur_valid && m_s >= 3 && m_s <= 6) ? exp_sel(m_cur_addr) : 3'b000;
    e_phi1 = (m_s == 7) || (m_s == 1) || (m_s == 2);
    e_phi0 = (m_s >= 3) && (m_s <= 6);
    e_rdy  = (m_s == 6);
    e_nwe  = !(m_cur_valid && m_cur_write);
    check("bus_model", bus_vec(), {e_phi1, e_phi0, e_rdy, m_A, e_nwe, ~sel, m_rsp, m_rdata});
    if (m_cur_valid && m_cur_write && m_s >= 4 && m_s <= 6)
      check("d_write", 32'(d_bus), 32'(m_cur_wdata));
    if (!nDEVSEL) n_dev++;
    if (!nIOSEL) n_io++;
    if (!nIOSTRB) n_strb++;
    if (rsp_valid) begin
      n_rsp++;
      rsp_q.push_back(cyc);
    end
    tb_drive = nRES && m_cur_valid && !m_cur_write && (m_s == 5 || m_s == 6);
    tb_data  = m_cur_rdata;
  endtask

  task automatic clear_obs();
    n_dev = 0; n_io = 0; n_strb = 0; n_rsp = 0;
    rsp_q.delete();
  endtask

  task automatic wait_ready(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(name, 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        write;
    logic [7:0]  wdata;
    logic [7:0]  bus_data;
    logic [2:0]  sel;     // {devsel, iosel, iostrb} expected to assert
    logic [7:0]  rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic run_vec(input vec_t v);
    bit ok;
    int acc;
    wait_ready("vec_ready");
    req_valid = 1'b1; req_addr = v.addr; req_write = v.write; req_wdata = v.wdata;
    next_rdata = v.bus_data;
    clear_obs();
    acc = cyc;
    tick();
    req_valid = 1'b0;
    req_addr = 16'hFFFF; req_write = ~v.write; req_wdata = ~v.wdata;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("vec_latency", ok ? 32'(cyc - acc) : 32'd0, 32'd8);
    check("vec_rdata", 32'(rsp_rdata), 32'(v.rdata));
    check("vec_selects", {8'd0, 8'(n_dev), 8'(n_io), 8'(n_strb)},
          {8'd0, v.sel[2] ? 8'd4 : 8'd0, v.sel[1] ? 8'd4 : 8'd0, v.sel[0] ? 8'd4 : 8'd0});
  endtask

  initial begin
    int n1, n0, bad, acc_cnt, hold;
    vecs[0]  = '{16'hC0C3, 1'b1, 8'hA5, 8'h00, 3'b100, 8'h00};
    vecs[1]  = '{16'hC400, 1'b0, 8'h00, 8'h3C, 3'b010, 8'h3C};
    vecs[2]  = '{16'hC0B0, 1'b0, 8'h00, 8'h77, 3'b000, 8'h77};
    vecs[3]  = '{16'hC500, 1'b0, 8'h00, 8'h11, 3'b000, 8'h11};
    vecs[4]  = '{16'hC0CF, 1'b1, 8'h5A, 8'h00, 3'b100, 8'h00};
    vecs[5]  = '{16'hC4FF, 1'b0, 8'h00, 8'hC3, 3'b010, 8'hC3};
    vecs[6]  = '{16'hC800, 1'b0, 8'h00, 8'hE1, 3'b001, 8'hE1};
    vecs[7]  = '{16'hCFFF, 1'b1, 8'h0F, 8'h00, 3'b001, 8'h00};
    vecs[8]  = '{16'hC07F, 1'b0, 8'h00, 8'h42, 3'b000, 8'h42};
    vecs[9]  = '{16'hC3FF, 1'b0, 8'h00, 8'h99, 3'b000, 8'h99};
    vecs[10] = '{16'hD000, 1'b0, 8'h00, 8'h24, 3'b000, 8'h24};
    vecs[11] = '{16'hC090, 1'b1, 8'h81, 8'h00, 3'b000, 8'h00};

    tb_drive = 1'b0; tb_data = 8'h00; next_rdata = 8'h00;
    req_valid = 1'b0; req_addr = 16'h0000; req_write = 1'b0; req_wdata = 8'h00;
    nRES = 1'b1;
    clear_obs();
    #2 nRES = 1'b0;

    // Reset hold: model check every cycle plus an explicit reset-value vector.
    for (int i = 0; i < 10; i++) tick();
    check("reset_values", bus_vec(), RESET_VEC);
    nRES = 1'b1;

    // Phase shape and quiet selects while idle.
    n1 = 0; n0 = 0; bad = 0;
    clear_obs();
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i < 7) begin
        n1 += int'(PHI1); n0 += int'(PHI0);
        if (PHI1 === PHI0) bad++;
      end
    end
    check("phi1_high_count", 32'(n1), 32'd3);
    check("phi0_high_count", 32'(n0), 32'd4);
    check("phi_complement", 32'(bad), 32'd0);
    check("idle_no_select", 32'(n_dev + n_io + n_strb + n_rsp), 32'd0);

    // Table-driven single transactions.
    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Back-to-back reads CFFF then C810 with req_valid held.
    wait_ready("b2b_ready1");
    clear_obs();
    req_valid = 1'b1; req_addr = 16'hCFFF; req_write = 1'b0; next_rdata = 8'h9A;
    tick();
    req_addr = 16'hC810; next_rdata = 8'h6B;
    for (int i = 0; i < 6; i++) tick();
    check("b2b_ready2", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_q.size() >= 2) break;
      tick();
    end
    check("b2b_rsp_count", 32'(rsp_q.size()), 32'd2);
    check("b2b_rsp_spacing", (rsp_q.size() >= 2) ? 32'(rsp_q[1] - rsp_q[0]) : 32'd0, 32'd7);
    check("b2b_iostrb_cycles", 32'(n_strb), 32'd8);
    check("b2b_last_rdata", 32'(rsp_rdata), 32'h6B);

    // Request withdrawn before S6 has no effect.
    wait_ready("wd_ready");
    for (int i = 0; i < 3; i++) tick();
    clear_obs();
    req_valid = 1'b1; req_addr = 16'hC0C4; req_write = 1'b1; req_wdata = 8'hEE;
    tick(); tick();
    req_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("withdraw_quiet", 32'(n_dev + n_io + n_strb + n_rsp), 32'd0);
    check("withdraw_nwe", 32'(nWE), 32'd1);

    // Reset asserted in S5 of a write to C0C0.
    wait_ready("rst_ready");
    req_valid = 1'b1; req_addr = 16'hC0C0; req_write = 1'b1; req_wdata = 8'h96;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("rst_pre_devsel", 32'(nDEVSEL), 32'd0);
    check("rst_pre_d", 32'(d_bus), 32'h96);
    #1 nRES = 1'b0;
    #1 check("rst_async_values", bus_vec(), RESET_VEC);
    clear_obs();
    for (int i = 0; i < 4; i++) tick();
    nRES = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check("rst_no_response", 32'(n_rsp), 32'd0);
    check("rst_clean_idle", 32'(n_dev + n_io + n_strb), 32'd0);

    // Random traffic against the model.
    clear_obs();
    acc_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      hold = int'($urandom_range(0, 8));
      for (int i = 0; i < hold; i++) tick();
      hold = int'($urandom_range(1, 10));
      req_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        case ($urandom_range(0, 5))
          0: req_addr = 16'hC0C0 | 16'($urandom_range(0, 15));
          1: req_addr = 16'hC400 | 16'($urandom_range(0, 255));
          2: req_addr = 16'hC800 + 16'($urandom_range(0, 16'h07FF));
          3: req_addr = 16'hC080 + 16'($urandom_range(0, 16'h007F));
          4: req_addr = 16'hC000 + 16'($urandom_range(0, 16'h0FFF));
          default: req_addr = 16'($urandom());
        endcase
        req_write  = 1'($urandom_range(0, 1));
        req_wdata  = 8'($urandom());
        next_rdata = 8'($urandom());
        if (req_ready === 1'b1) acc_cnt++;
        tick();
      end
      req_valid = 1'b0;
    end
    for (int i = 0; i < 16; i++) tick();
    check("rand_rsp_count", 32'(n_rsp), 32'(acc_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
